copperv_mem_arbiter: RTL and testbench
======================================

Name: copperv_mem_arbiter

Overview:
- Parametrised N-channel arbiter between requesters (fetch, load/store, debug) and one memory port.
- Uses the core's memory command/response convention: addr, wr_data, en, we / rd_data, ready.
- Generalised over the single-port form: configurable address/data width, channel count, byte write strobes, round-robin fairness, a response timeout with error flag, and per-channel transaction counters.

Parameters:
NUM_CH, 2, number of requester channels (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
TIMEOUT, 255, cycles to wait for mem_rsp_ready before aborting; 0 disables the timeout
CNT_W, 16, per-channel completed-transaction counter width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_en  in  NUM_CH  per-channel request; held until that channel's rsp_ready
req_we  in  NUM_CH  per-channel write enable
req_addr  in  NUM_CH*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W]
req_wr_data  in  NUM_CH*DATA_W  packed write data
req_strb  in  NUM_CH*DATA_W/8  packed byte strobes; ignored on reads
rsp_ready  out  NUM_CH  one-cycle completion pulse per channel
rsp_err  out  NUM_CH  timeout flag; valid with rsp_ready
rsp_rd_data  out  DATA_W  read data; broadcast, valid for the channel with rsp_ready high
mem_en  out  1  memory command valid
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wr_data  out  DATA_W  memory write data
mem_strb  out  DATA_W/8  memory byte strobes
mem_rd_data  in  DATA_W  memory read data
mem_rsp_ready  in  1  memory completion, single-cycle, valid only while mem_en is high
grant  out  NUM_CH  one-hot owner of the current transaction; 0 when idle
txn_count  out  NUM_CH*CNT_W  packed completed-transaction counts per channel

Behaviour:
- Reset values: all outputs 0; round-robin pointer at channel 0; timeout counter 0; state IDLE.
- FSM has three states, one transaction outstanding at a time.
- IDLE:
  - If any req_en is set, select the first set bit at or after the pointer, wrapping modulo NUM_CH.
  - Register grant and the selected channel's we/addr/wr_data/strb onto the mem_* outputs.
  - Set mem_en; go to BUSY. Latency from req_en to mem_en is 1 cycle.
- BUSY:
  - mem_* outputs are held stable; the requester's fields are not re-sampled.
  - On mem_rsp_ready: capture mem_rd_data into rsp_rd_data, drop mem_en, go to RESP.
  - The timeout counter increments each BUSY cycle without mem_rsp_ready.
  - When the counter reaches TIMEOUT with TIMEOUT nonzero: drop mem_en, set rsp_rd_data to 0, set the error flag, go to RESP.
  - mem_rsp_ready in the same cycle the counter reaches TIMEOUT: the response wins and no error is flagged.
- RESP (one cycle):
  - rsp_ready[g] = 1; rsp_err[g] = error flag.
  - Pointer moves to (g+1) mod NUM_CH.
  - txn_count[g] increments, wrapping at 2^CNT_W; timeouts are counted too.
  - Next state IDLE. grant clears on entry to IDLE.
- Minimum transaction: mem_en in cycle t+1, mem_rsp_ready in t+1, rsp_ready in t+2, next grant in t+3.
  - Channel g must drop or replace req_en at the clock edge where it sees rsp_ready.
- req_en changes on other channels during BUSY/RESP do not affect the current grant.
- A channel dropping req_en while granted is a protocol violation: the transaction still completes and the response is still pulsed.
- mem_rsp_ready outside BUSY is ignored.
- Write data and strobe are passed through unmodified; mem_rd_data is returned unmodified on writes too.
- rstn asserted mid-transaction clears all state immediately (mem_en, rsp_ready and grant go to 0). No response is emitted after release; requesters must reissue.
- NUM_CH=1: the pointer is constant 0 and the behaviour is otherwise identical.

Test Plan:
- Single read: NUM_CH=2; ch0 reads 0x100; memory returns 0xDEADBEEF after 3 cycles -> mem_en high 3 cycles with mem_addr=0x100, mem_we=0; then rsp_ready=2'b01, rsp_rd_data=0xDEADBEEF, rsp_err=0; txn_count[0]=1.
- Write strobes: ch1 writes 0xA5A5A5A5 to 0x40 with strb 4'b0011 -> mem_we=1, mem_strb=0011, mem_wr_data=0xA5A5A5A5; then rsp_ready=2'b10.
- Fairness: ch0 and ch1 both hold req_en for 4 back-to-back transactions, memory ready immediately -> grant sequence 01,10,01,10 with new grants at cycles 1,4,7,10.
- Timeout: TIMEOUT=5, memory never ready -> mem_en high exactly 5 cycles; then rsp_ready and rsp_err pulse for the granted channel with rsp_rd_data=0. A subsequent request proceeds normally.
- Ready at the deadline: mem_rsp_ready coincides with the timeout cycle -> rsp_err=0 and data returned.
- Reset mid-BUSY: rstn low for 1 cycle during BUSY -> mem_en, grant, rsp_ready 0 within that cycle; pointer 0, txn_count 0, no rsp_ready pulse after release.

Source files
------------

// File: rtl/copperv_mem_arbiter_if.sv
// Bundle of the requester and memory-side signals of the arbiter.
// The arbiter is the slave; the requesters and memory model are the master.
interface copperv_mem_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic [NUM_CH-1:0]          req_en;
    logic [NUM_CH-1:0]          req_we;
    logic [NUM_CH*ADDR_W-1:0]   req_addr;
    logic [NUM_CH*DATA_W-1:0]   req_wr_data;
    logic [NUM_CH*DATA_W/8-1:0] req_strb;
    logic [NUM_CH-1:0]          rsp_ready;
    logic [NUM_CH-1:0]          rsp_err;
    logic [DATA_W-1:0]          rsp_rd_data;
    logic                       mem_en;
    logic                       mem_we;
    logic [ADDR_W-1:0]          mem_addr;
    logic [DATA_W-1:0]          mem_wr_data;
    logic [DATA_W/8-1:0]        mem_strb;
    logic [DATA_W-1:0]          mem_rd_data;
    logic                       mem_rsp_ready;
    logic [NUM_CH-1:0]          grant;
    logic [NUM_CH*CNT_W-1:0]    txn_count;

    modport slave (
        input  req_en, req_we, req_addr, req_wr_data, req_strb, mem_rd_data, mem_rsp_ready,
        output rsp_ready, rsp_err, rsp_rd_data, mem_en, mem_we, mem_addr, mem_wr_data,
               mem_strb, grant, txn_count
    );

    modport master (
        output req_en, req_we, req_addr, req_wr_data, req_strb, mem_rd_data, mem_rsp_ready,
        input  rsp_ready, rsp_err, rsp_rd_data, mem_en, mem_we, mem_addr, mem_wr_data,
               mem_strb, grant, txn_count
    );
endinterface

// File: rtl/copperv_mem_arbiter.sv
// Round-robin N-channel arbiter onto a single memory port, one transaction
// in flight, with response timeout and per-channel completion counters.
module copperv_mem_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    copperv_mem_arbiter_if.slave bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                         state_q;
    logic [PTR_W-1:0]               ptr_q;
    logic [PTR_W-1:0]               gidx_q;
    logic [TO_W-1:0]                to_cnt_q;
    logic [NUM_CH-1:0]              grant_q;
    logic [NUM_CH-1:0]              rsp_ready_q;
    logic [NUM_CH-1:0]              rsp_err_q;
    logic [DATA_W-1:0]              rsp_rd_data_q;
    logic                           mem_en_q;
    logic                           mem_we_q;
    logic [ADDR_W-1:0]              mem_addr_q;
    logic [DATA_W-1:0]              mem_wr_data_q;
    logic [STRB_W-1:0]              mem_strb_q;
    logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q;

    logic [PTR_W-1:0]               sel;
    logic                           sel_vld;
    logic [PTR_W-1:0]               ptr_d;

    // First requester at or after the pointer, wrapping modulo NUM_CH.
    always_comb begin
        logic [PTR_W:0]   idx;
        logic [PTR_W-1:0] cand;
        sel     = '0;
        sel_vld = 1'b0;
        idx     = '0;
        cand    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(NUM_CH))
                idx = idx - (PTR_W+1)'(NUM_CH);
            cand = idx[PTR_W-1:0];
            if (!sel_vld && bus.req_en[cand]) begin
                sel_vld = 1'b1;
                sel     = cand;
            end
        end
    end

    assign ptr_d = (int'(gidx_q) + 1 >= NUM_CH) ? '0 : gidx_q + PTR_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            gidx_q        <= '0;
            to_cnt_q      <= '0;
            grant_q       <= '0;
            rsp_ready_q   <= '0;
            rsp_err_q     <= '0;
            rsp_rd_data_q <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            mem_strb_q    <= '0;
            cnt_q         <= '0;
        end else begin
            rsp_ready_q <= '0;
            rsp_err_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (sel_vld) begin
                        grant_q       <= NUM_CH'(1) << sel;
                        gidx_q        <= sel;
                        mem_en_q      <= 1'b1;
                        mem_we_q      <= bus.req_we[sel];
                        mem_addr_q    <= bus.req_addr[sel*ADDR_W +: ADDR_W];
                        mem_wr_data_q <= bus.req_wr_data[sel*DATA_W +: DATA_W];
                        mem_strb_q    <= bus.req_strb[sel*STRB_W +: STRB_W];
                        to_cnt_q      <= '0;
                        state_q       <= BUSY;
                    end
                end
                BUSY: begin
                    // A response in the deadline cycle beats the timeout.
                    if (bus.mem_rsp_ready ||
                        (TIMEOUT != 0 && to_cnt_q == TO_W'(TIMEOUT - 1))) begin
                        rsp_rd_data_q  <= bus.mem_rsp_ready ? bus.mem_rd_data : '0;
                        rsp_ready_q    <= grant_q;
                        rsp_err_q      <= bus.mem_rsp_ready ? '0 : grant_q;
                        mem_en_q       <= 1'b0;
                        cnt_q[gidx_q]  <= cnt_q[gidx_q] + CNT_W'(1);
                        ptr_q          <= ptr_d;
                        state_q        <= RESP;
                    end else if (TIMEOUT != 0) begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                RESP: begin
                    grant_q <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.rsp_ready   = rsp_ready_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_rd_data = rsp_rd_data_q;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wr_data = mem_wr_data_q;
    assign bus.mem_strb    = mem_strb_q;
    assign bus.txn_count   = cnt_q;
endmodule

// File: tb/tb_copperv_mem_arbiter.sv
// Directed bench for copperv_mem_arbiter: a transaction table plus hand
// sequences for round-robin fairness and reset during a busy transaction.
module tb_copperv_mem_arbiter;
    localparam int NUM_CH  = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 5;
    localparam int CNT_W   = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    copperv_mem_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    copperv_mem_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    typedef struct {
        int          ch;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          delay;    // mem_en cycle in which memory answers, 0 = never
        logic [31:0] rdata;
        int          exp_cyc;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_en        = '0;
        bus.req_we        = '0;
        bus.req_addr      = '0;
        bus.req_wr_data   = '0;
        bus.req_strb      = '0;
        bus.mem_rd_data   = '0;
        bus.mem_rsp_ready = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        int cyc = 0;
        int guard = 0;
        bus.req_en                       = '0;
        bus.req_en[v.ch]                 = 1'b1;
        bus.req_we[v.ch]                 = v.we;
        bus.req_addr[v.ch*32 +: 32]      = v.addr;
        bus.req_wr_data[v.ch*32 +: 32]   = v.wdata;
        bus.req_strb[v.ch*4 +: 4]        = v.strb;
        @(posedge clk); #1;
        chk("grant", 64'(bus.grant), 64'(2'b01 << v.ch));
        while (bus.mem_en && guard < 40) begin
            cyc++;
            guard++;
            chk("mem_addr", 64'(bus.mem_addr), 64'(v.addr));
            if (cyc == 1) begin
                chk("mem_we", 64'(bus.mem_we), 64'(v.we));
                chk("mem_wr_data", 64'(bus.mem_wr_data), 64'(v.wdata));
                chk("mem_strb", 64'(bus.mem_strb), 64'(v.strb));
            end
            bus.mem_rsp_ready = (cyc == v.delay);
            bus.mem_rd_data   = (cyc == v.delay) ? v.rdata : 32'hBAD0BAD0;
            @(posedge clk); #1;
        end
        bus.mem_rsp_ready = 1'b0;
        chk("mem_en_cycles", 64'(cyc), 64'(v.exp_cyc));
        chk("rsp_ready", 64'(bus.rsp_ready), 64'(2'b01 << v.ch));
        chk("rsp_err", 64'(bus.rsp_err), 64'(v.exp_err ? (2'b01 << v.ch) : 2'b00));
        chk("rsp_rd_data", 64'(bus.rsp_rd_data), 64'(v.exp_rd));
        chk("txn_count", 64'(bus.txn_count[v.ch*16 +: 16]), 64'(v.exp_cnt));
        bus.req_en = '0;
        @(posedge clk); #1;
        chk("grant_idle", 64'(bus.grant), 64'd0);
        chk("rsp_ready_after", 64'(bus.rsp_ready), 64'd0);
    endtask

    logic [1:0] exp_grant[13];
    int         pulses;

    initial begin
        vecs[0] = '{0, 1'b0, 32'h100,      32'h0,        4'hF, 3, 32'hDEADBEEF, 3, 1'b0, 32'hDEADBEEF, 1};
        vecs[1] = '{1, 1'b1, 32'h40,       32'hA5A5A5A5, 4'h3, 1, 32'h12345678, 1, 1'b0, 32'h12345678, 1};
        vecs[2] = '{0, 1'b0, 32'h200,      32'h0,        4'hF, 0, 32'h0,        5, 1'b1, 32'h0,        2};
        vecs[3] = '{1, 1'b0, 32'h80,       32'h0,        4'hF, 5, 32'hCAFEF00D, 5, 1'b0, 32'hCAFEF00D, 2};
        vecs[4] = '{0, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFF, 4'hF, 2, 32'h0,        2, 1'b0, 32'h0,        3};
        vecs[5] = '{1, 1'b0, 32'h0,        32'h0,        4'hA, 4, 32'h00000001, 4, 1'b0, 32'h00000001, 3};
        exp_grant = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                      2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};

        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
        chk("rst_grant", 64'(bus.grant), 64'd0);
        chk("rst_rsp_ready", 64'(bus.rsp_ready), 64'd0);
        chk("rst_txn_count", 64'(bus.txn_count), 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Both channels hold requests; memory answers in the first mem_en cycle.
        bus.req_en = 2'b11;
        bus.req_we = 2'b00;
        bus.req_addr = {32'h1111_0000, 32'h0000_1111};
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            chk($sformatf("fair_grant_c%0d", i), 64'(bus.grant), 64'(exp_grant[i]));
            bus.mem_rsp_ready = bus.mem_en;
            bus.mem_rd_data   = 32'h5A5A0000 + 32'(i);
            if (i == 11) bus.req_en = '0;
        end
        bus.mem_rsp_ready = 1'b0;
        chk("fair_cnt0", 64'(bus.txn_count[15:0]), 64'd5);
        chk("fair_cnt1", 64'(bus.txn_count[31:16]), 64'd5);

        // Move the pointer to ch1, then reset while ch1 is in BUSY.
        run_txn('{0, 1'b0, 32'h300, 32'h0, 4'hF, 1, 32'h77, 1, 1'b0, 32'h77, 6});
        bus.req_en = 2'b10;
        @(posedge clk); #1;
        chk("pre_rst_grant", 64'(bus.grant), 64'(2'b10));
        chk("pre_rst_mem_en", 64'(bus.mem_en), 64'd1);
        rstn = 1'b0;
        bus.req_en = '0;
        #1;
        chk("midrst_mem_en", 64'(bus.mem_en), 64'd0);
        chk("midrst_grant", 64'(bus.grant), 64'd0);
        chk("midrst_rsp_ready", 64'(bus.rsp_ready), 64'd0);
        chk("midrst_txn_count", 64'(bus.txn_count), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_ready != '0) pulses++;
        end
        chk("post_rst_pulses", 64'(pulses), 64'd0);
        bus.req_en = 2'b11;
        @(posedge clk); #1;
        chk("post_rst_ptr_grant", 64'(bus.grant), 64'(2'b01));
        bus.mem_rsp_ready = 1'b1;
        bus.mem_rd_data   = 32'h0BADF00D;
        @(posedge clk); #1;
        bus.mem_rsp_ready = 1'b0;
        chk("post_rst_rsp_ready", 64'(bus.rsp_ready), 64'(2'b01));
        chk("post_rst_rd_data", 64'(bus.rsp_rd_data), 64'h0BADF00D);
        chk("post_rst_cnt0", 64'(bus.txn_count[15:0]), 64'd1);
        bus.req_en = '0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
